// File: rtl/dvs_ravens_pkg.sv
// Shared types and widths for the DVS event -> RAVENS reader path.
package dvs_ravens_pkg;

  localparam int EVENT_BITS         = 16;
  localparam int FIFO_DROP_CNT_BITS = 16;

  // Event queue read-arbitration states
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RD_WAIT,
    ARB_DATA
  } arb_state_e;

endpackage

// File: rtl/dvs_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module dvs_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   cand;
  logic found;

  // Scan N candidates starting one past the previous winner
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dvs_event_fifo_arbiter.sv
// DVS event queue with round-robin grant / rd_en / data handshake to readers.
module dvs_event_fifo_arbiter
  import dvs_ravens_pkg::*;
#(
  parameter  int NUM_READERS = 2,
  parameter  int DEPTH       = 16,
  localparam int PTR_BITS    = $clog2(DEPTH),
  localparam int IW          = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [EVENT_BITS-1:0]         wr_event,
  input  logic [NUM_READERS-1:0]        fifo_req,
  input  logic [NUM_READERS-1:0]        fifo_rd_en,
  output logic [NUM_READERS-1:0]        fifo_grant,
  output logic [EVENT_BITS-1:0]         fifo_event,
  output logic                          full,
  output logic                          empty,
  output logic [PTR_BITS:0]             fill_level,
  output logic                          overflow,
  output logic [FIFO_DROP_CNT_BITS-1:0] drop_count
);

  logic [EVENT_BITS-1:0]  mem [DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
  logic [PTR_BITS:0]      count;
  arb_state_e             state, state_nxt;
  logic [IW-1:0]          last;
  logic [NUM_READERS-1:0] arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_go, pop, push, drop;

  assign full       = (count == (PTR_BITS+1)'(DEPTH));
  assign empty      = (count == '0);
  assign fill_level = count;

  // 'last' doubles as the current winner while a grant is in flight
  assign arb_go = (state == ARB_IDLE) && !empty && (|fifo_req);
  assign pop    = (state == ARB_RD_WAIT) && fifo_rd_en[last];
  assign push   = wr_en && (!full || pop);
  assign drop   = wr_en && full && !pop;

  dvs_rr_arbiter #(.N(NUM_READERS)) u_rr (
    .req  (fifo_req),
    .last (last),
    .en   (arb_go),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Next-state: one grant in flight, aborted read falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (arb_go) state_nxt = ARB_GRANT;
      ARB_GRANT:   state_nxt = ARB_RD_WAIT;
      ARB_RD_WAIT: state_nxt = pop ? ARB_DATA : ARB_IDLE;
      ARB_DATA:    state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // FSM, grant pulse and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      fifo_grant <= '0;
      last       <= IW'(NUM_READERS - 1);
    end else begin
      state      <= state_nxt;
      fifo_grant <= arb_go ? arb_gnt : '0;
      if (arb_go) last <= arb_idx;
    end
  end

  // Storage is not reset; occupancy tracking alone decides validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_event;
  end

  // Pointers, occupancy, popped event register and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_event <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fifo_event <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
